// File: rtl/corefifo_rd_ptr_status_if.sv
// Read-side FIFO pointer/status bundle.
// The underflow signal exists only when RD_UNDERFLOW_EN is defined.
interface corefifo_rd_ptr_status_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 re;
    logic [ADDRWIDTH:0]   wptr_bin_sync;
    logic [ADDRWIDTH-1:0] raddr;
    logic [ADDRWIDTH:0]   rptr_gray;
    logic                 empty;
    logic                 almost_empty;
    logic [ADDRWIDTH:0]   rd_cnt;
    logic                 dvld;
`ifdef RD_UNDERFLOW_EN
    logic                 underflow;
`endif

    modport master (
        output re, wptr_bin_sync,
        input  raddr, rptr_gray, empty, almost_empty, rd_cnt, dvld
`ifdef RD_UNDERFLOW_EN
        , input underflow
`endif
    );

    modport slave (
        input  re, wptr_bin_sync,
        output raddr, rptr_gray, empty, almost_empty, rd_cnt, dvld
`ifdef RD_UNDERFLOW_EN
        , output underflow
`endif
    );
endinterface

// File: rtl/corefifo_rd_ptr_status.sv
// Read pointer, Gray pointer and status flags of the async FIFO read side.
// Optional RD_UNDERFLOW_EN adds a registered underflow pulse.
module corefifo_rd_ptr_status #(
    parameter int ADDRWIDTH = 3,
    parameter int AEVAL     = 1
) (
    input logic                    clk,
    input logic                    reset_n,
    corefifo_rd_ptr_status_if.slave bus
);
    localparam logic [ADDRWIDTH:0] AE_TH = (ADDRWIDTH+1)'(AEVAL);
    localparam logic [ADDRWIDTH:0] ONE   = (ADDRWIDTH+1)'(1);

    logic [ADDRWIDTH:0] rptr_bin;
    logic [ADDRWIDTH:0] rptr_next;
    logic [ADDRWIDTH:0] cnt_next;
    logic [ADDRWIDTH:0] rptr_gray_q;
    logic [ADDRWIDTH:0] rd_cnt_q;
    logic               empty_q;
    logic               almost_empty_q;
    logic               dvld_q;
    logic               rd_ok;

    // Flags look at the post-read pointer so the draining read
    // raises empty on the very next edge.
    always_comb begin
        rd_ok     = bus.re & ~empty_q;
        rptr_next = rd_ok ? rptr_bin + ONE : rptr_bin;
        cnt_next  = bus.wptr_bin_sync - rptr_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rptr_bin       <= '0;
            rptr_gray_q    <= '0;
            rd_cnt_q       <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            dvld_q         <= 1'b0;
        end else begin
            rptr_bin       <= rptr_next;
            rptr_gray_q    <= rptr_next ^ (rptr_next >> 1);
            rd_cnt_q       <= cnt_next;
            empty_q        <= (cnt_next == '0);
            almost_empty_q <= (cnt_next <= AE_TH);
            dvld_q         <= rd_ok;
        end
    end

`ifdef RD_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) underflow_q <= 1'b0;
        else          underflow_q <= bus.re & empty_q;
    end

    assign bus.underflow = underflow_q;
`endif

    assign bus.raddr        = rptr_bin[ADDRWIDTH-1:0];
    assign bus.rptr_gray    = rptr_gray_q;
    assign bus.rd_cnt       = rd_cnt_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.dvld         = dvld_q;
endmodule

// File: tb/tb_corefifo_rd_ptr_status.sv
// Bench for corefifo_rd_ptr_status (ADDRWIDTH=3, AEVAL=1).
// Reference tracks total words written/read as unbounded integers.
module tb_corefifo_rd_ptr_status;
    localparam int AW    = 3;
    localparam int AEV   = 1;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 2 * DEPTH;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    corefifo_rd_ptr_status_if #(.ADDRWIDTH(AW)) bus ();

    corefifo_rd_ptr_status #(.ADDRWIDTH(AW), .AEVAL(AEV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;
    int m_w   = 0;
    int m_rd  = 0;
    int m_cnt = 0;
    bit m_dvld = 0;
    bit m_uf   = 0;
    logic [AW:0] prev_gray = '0;

    function automatic int pmod(input int v);
        return ((v % PMOD) + PMOD) % PMOD;
    endfunction

    function automatic int gray_of(input int n);
        int b;
        b = pmod(n);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_cnt"},   32'(bus.rd_cnt),       32'(m_cnt));
        chk({tag, "_empty"}, 32'(bus.empty),        32'(m_cnt == 0));
        chk({tag, "_ae"},    32'(bus.almost_empty), 32'(m_cnt <= AEV));
        chk({tag, "_raddr"}, 32'(bus.raddr),        32'(m_rd % DEPTH));
        chk({tag, "_gray"},  32'(bus.rptr_gray),    32'(gray_of(m_rd)));
        chk({tag, "_dvld"},  32'(bus.dvld),         32'(m_dvld));
`ifdef RD_UNDERFLOW_EN
        chk({tag, "_uf"},    32'(bus.underflow),    32'(m_uf));
`endif
    endtask

    // One clock: drive at negedge, check 1 time unit after posedge.
    task automatic step(input string tag, input bit r, input int w_total);
        bit ok;
        @(negedge clk);
        bus.re = r;
        bus.wptr_bin_sync = (AW+1)'(pmod(w_total));
        prev_gray = bus.rptr_gray;
        ok = r && (m_cnt != 0);
        m_uf = r && (m_cnt == 0);
        m_w = w_total;
        @(posedge clk);
        #1;
        m_rd += int'(ok);
        m_dvld = ok;
        m_cnt = pmod(m_w - m_rd);
        chk_all(tag);
        if (ok)
            chk({tag, "_gray1bit"},
                32'($countones(prev_gray ^ bus.rptr_gray)), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        m_w = 0; m_rd = 0; m_cnt = 0; m_dvld = 0; m_uf = 0;
        chk_all("rst_async");
        bus.re = 1'b0;
        bus.wptr_bin_sync = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int w;
        bus.re = 1'b0;
        bus.wptr_bin_sync = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_init");
        @(negedge clk);
        reset_n = 1'b1;

        step("idle", 0, 0);
        step("idle", 0, 0);

        // fill to 3 then drain
        step("fill", 0, 3);
        chk("fill_cnt3", 32'(bus.rd_cnt), 32'd3);
        step("drain1", 1, 3);
        step("drain2", 1, 3);
        chk("drain2_ae", 32'(bus.almost_empty), 32'd1);
        step("drain3", 1, 3);
        chk("drain3_empty", 32'(bus.empty), 32'd1);
        chk("drain3_raddr", 32'(bus.raddr), 32'd3);

        // reads while empty are ignored
        repeat (4) step("rd_empty", 1, 3);

        // simultaneous read + write keeps count at 1
        step("simul_pre", 0, 4);
        step("simul", 1, 5);
        chk("simul_cnt1", 32'(bus.rd_cnt), 32'd1);

        // 20 write/read pairs across the pointer wrap
        w = m_w;
        for (int i = 0; i < 20; i++) begin
            w++;
            step("wrap", 1, w);
        end
        step("wrap_end", 1, w);

        // full: wptr=8 with rptr=0, then wptr=12 with rptr=4
        do_reset();
        step("post_rst", 0, 0);
        step("full0", 0, 8);
        chk("full0_cnt8", 32'(bus.rd_cnt), 32'd8);
        repeat (4) step("full_rd", 1, 8);
        step("full4", 0, 12);
        chk("full4_cnt8", 32'(bus.rd_cnt), 32'd8);
        chk("full4_nempty", 32'(bus.empty), 32'd0);

        // randomized traffic inside the legal range
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int room;
            int adv;
            room = DEPTH - (m_w - m_rd);
            adv = (room > 0) ? int'($urandom_range(0, (room > 2) ? 2 : room)) : 0;
            step("rand", 1'($urandom_range(0, 1)), m_w + adv);
        end

        // reset mid-operation with data pending
        step("pre_rst", 0, m_w + 2);
        do_reset();
        step("after_rst", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
